// File: rtl/synchronous_down_counter.sv
// ============================================================================
//  Module   : synchronous_down_counter
//  Purpose  : Parameterised synchronous down counter/timer with load, enable,
//             one-shot mode and a one-cycle underflow pulse.
//  Option   : SYNCHRONOUS_DOWN_COUNTER_AUTO_RELOAD_EN -- when defined, a
//             free-run underflow restores the last loaded value instead of
//             wrapping to all ones.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module synchronous_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             one_shot,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             uf,
    output logic             busy
);

    localparam logic [WIDTH-1:0] c_ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] c_ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
        $error("synchronous_down_counter: WIDTH must be in 2..16");
    end

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_uf_nxt;
    logic [WIDTH-1:0] w_wrap_val;

`ifdef SYNCHRONOUS_DOWN_COUNTER_AUTO_RELOAD_EN
    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] w_reload_nxt;

    assign w_wrap_val = r_reload;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_reload <= c_ALL_ONES;
        end else begin
            r_reload <= w_reload_nxt;
        end
    end

    always_comb begin
        w_reload_nxt = r_reload;
        if (load) begin
            w_reload_nxt = load_val;
        end
    end
`else
    assign w_wrap_val = c_ALL_ONES;
`endif

    // Load overrides everything except reset, including a pending underflow.
    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = q;
        w_uf_nxt    = 1'b0;
        if (load) begin
            w_q_nxt     = load_val;
            w_state_nxt = ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (en) begin
                        if (q != c_ZERO) begin
                            w_q_nxt = q - c_ONE;
                        end else begin
                            w_uf_nxt = 1'b1;
                            if (one_shot) begin
                                w_state_nxt = ST_HOLD;
                            end else begin
                                w_q_nxt = w_wrap_val;
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    w_q_nxt = c_ZERO;
                end
                default: begin
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            q       <= c_ALL_ONES;
            uf      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            q       <= w_q_nxt;
            uf      <= w_uf_nxt;
        end
    end

    assign tc   = (q == c_ZERO);
    assign busy = (r_state == ST_RUN);

endmodule

`default_nettype wire

// File: tb/tb_synchronous_down_counter.sv
// ============================================================================
//  Module   : tb_synchronous_down_counter
//  Purpose  : Directed plus randomized check of synchronous_down_counter
//             against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_synchronous_down_counter;

    localparam int W       = 4;
    localparam int MOD     = 1 << W;
    localparam int ALL_ONE = MOD - 1;
`ifdef SYNCHRONOUS_DOWN_COUNTER_AUTO_RELOAD_EN
    localparam bit AUTO_RELOAD = 1'b1;
`else
    localparam bit AUTO_RELOAD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         load;
    logic [W-1:0] load_val;
    logic         one_shot;
    logic [W-1:0] q;
    logic         tc;
    logic         uf;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: plain integers plus a running/stopped flag.
    int m_q;
    int m_reload;
    bit m_run;
    bit m_uf;

    always #5 clk = ~clk;

    synchronous_down_counter #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .one_shot (one_shot),
        .q        (q),
        .tc       (tc),
        .uf       (uf),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model, then compare all outputs.
    task automatic cycle(input bit r, input bit l, input bit e, input bit os,
                         input int lv, input string tag);
        rst      = r;
        load     = l;
        en       = e;
        one_shot = os;
        load_val = lv[W-1:0];
        @(posedge clk);
        if (r) begin
            m_q = ALL_ONE; m_reload = ALL_ONE; m_run = 1'b1; m_uf = 1'b0;
        end else if (l) begin
            m_q = lv % MOD; m_reload = lv % MOD; m_run = 1'b1; m_uf = 1'b0;
        end else if (m_run && e) begin
            if (m_q == 0) begin
                m_uf = 1'b1;
                if (os) m_run = 1'b0;
                else    m_q = AUTO_RELOAD ? m_reload : ALL_ONE;
            end else begin
                m_q  = (m_q + MOD - 1) % MOD;
                m_uf = 1'b0;
            end
        end else begin
            m_uf = 1'b0;
        end
        #1;
        check({tag, "_q"},    32'(q),    32'(m_q));
        check({tag, "_tc"},   32'(tc),   32'(m_q == 0));
        check({tag, "_uf"},   32'(uf),   32'(m_uf));
        check({tag, "_busy"}, 32'(busy), 32'(m_run));
    endtask

    initial begin
        rst = 1'b0; load = 1'b0; en = 1'b0; one_shot = 1'b0; load_val = '0;
        m_q = 0; m_reload = 0; m_run = 1'b1; m_uf = 1'b0;
        @(negedge clk);

        // Reset state
        cycle(1, 0, 0, 0, 0, "reset");
        check("reset_q_const", 32'(q), 32'd15);
        check("reset_tc_const", 32'(tc), 32'd0);

        // Free-run after reset: 15 down to 0, then wrap with one uf pulse
        for (int i = 1; i <= 17; i++) begin
            cycle(0, 0, 1, 0, 0, "freerun");
            if (i == 15) check("freerun_zero_tc", 32'(tc), 32'd1);
            if (i == 16) begin
                check("freerun_wrap_q", 32'(q), 32'd15);
                check("freerun_wrap_uf", 32'(uf), 32'd1);
            end
            if (i == 17) check("freerun_uf_width", 32'(uf), 32'd0);
        end

        // One-shot: 5..0, single uf, then parked at zero
        cycle(0, 1, 0, 0, 5, "os_load");
        check("os_load_q", 32'(q), 32'd5);
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, 1, 0, "os_count");
        check("os_zero_q", 32'(q), 32'd0);
        cycle(0, 0, 1, 1, 0, "os_uf");
        check("os_uf_pulse", 32'(uf), 32'd1);
        check("os_busy_low", 32'(busy), 32'd0);
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, 1, i[0], 0, "os_hold");
            check("os_hold_uf", 32'(uf), 32'd0);
        end

        // Reload vs wrap
        cycle(0, 1, 0, 0, 3, "rl_load");
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0, 0, "rl_run");
        check("rl_after_wrap", 32'(q), AUTO_RELOAD ? 32'd2 : 32'd14);

        // Simultaneous events
        cycle(0, 1, 0, 0, 9, "sim_load9");
        cycle(0, 1, 1, 0, 4, "sim_load_en");
        check("sim_load_wins", 32'(q), 32'd4);
        cycle(1, 1, 0, 0, 2, "sim_rst_load");
        check("sim_rst_wins", 32'(q), 32'd15);
        cycle(0, 1, 0, 0, 0, "sim_load0");
        check("load0_tc", 32'(tc), 32'd1);
        cycle(0, 1, 1, 0, 7, "sim_load_uf");
        check("load_blocks_uf", 32'(uf), 32'd0);

        // Reset mid-count
        cycle(0, 1, 0, 0, 6, "mid_load6");
        cycle(1, 0, 1, 0, 0, "mid_rst");
        check("mid_rst_q", 32'(q), 32'd15);
        cycle(0, 0, 1, 0, 0, "mid_resume");
        check("mid_resume_q", 32'(q), 32'd14);

        // Enable gating
        cycle(0, 1, 0, 0, 7, "gate_load7");
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0, "gate_off");
        check("gate_hold_q", 32'(q), 32'd7);
        cycle(0, 0, 1, 0, 0, "gate_on");
        check("gate_resume_q", 32'(q), 32'd6);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(99) < 2, $urandom_range(99) < 8,
                  $urandom_range(99) < 80, $urandom_range(99) < 30,
                  int'($urandom_range(ALL_ONE)), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
